// File: rtl/vector_merge_unit.sv
// Element-wise masked merge (vmerge.v*m) and unmasked move (vmv.v.*) for one
// 64-bit vector register slice. One registered stage, 1-cycle latency, no stall.
module vector_merge_unit #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [1:0]            vsew,
  input  logic                  vm,
  input  logic [DATA_WIDTH-1:0] vs2,
  input  logic [DATA_WIDTH-1:0] vs1,
  input  logic [DATA_WIDTH-1:0] v0,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] vd
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = $clog2(MASK_WIDTH);

  logic [MASK_WIDTH-1:0] mask;
  logic [NumBytes-1:0]   byte_sel;
  logic [DATA_WIDTH-1:0] vd_d, vd_q;
  logic                  out_valid_q;

  // Only the low MASK_WIDTH bits of v0 can ever address an element.
  assign mask = v0[MASK_WIDTH-1:0];

  logic unused_v0;
  assign unused_v0 = ^v0[DATA_WIDTH-1:MASK_WIDTH];

  // Per-byte select: byte b belongs to element b >> vsew (2^vsew bytes per element).
  always_comb begin
    byte_sel = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      logic [IdxW-1:0] byte_idx;
      logic [IdxW-1:0] elem_idx;
      byte_idx = IdxW'(b);
      unique case (vsew)
        2'b00:   elem_idx = byte_idx;
        2'b01:   elem_idx = byte_idx >> 1;
        2'b10:   elem_idx = byte_idx >> 2;
        default: elem_idx = '0;
      endcase
      byte_sel[b] = vm | mask[elem_idx];
    end
  end

  // Byte-granular merge network; a set select takes vs1, otherwise vs2.
  always_comb begin
    vd_d = vd_q;
    if (in_valid) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        vd_d[b*8 +: 8] = byte_sel[b] ? vs1[b*8 +: 8] : vs2[b*8 +: 8];
      end
    end
  end

  // Result register; reset wins over a same-cycle operation, idle cycles hold vd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vd_q        <= vd_d;
      out_valid_q <= in_valid;
    end
  end

  assign vd        = vd_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vector_merge_unit.sv
// Scoreboard bench for vector_merge_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_vector_merge_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  vsew;
  logic        vm;
  logic [63:0] vs2, vs1, v0;
  logic        out_valid;
  logic [63:0] vd;

  vector_merge_unit #(
    .DATA_WIDTH(64),
    .MASK_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .vsew     (vsew),
    .vm       (vm),
    .vs2      (vs2),
    .vs1      (vs1),
    .v0       (v0),
    .out_valid(out_valid),
    .vd       (vd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] vd;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [63:0] held = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: bit k lives in element k / SEW; mask bit of that element picks vs1.
  function automatic logic [63:0] ref_merge(input logic [1:0] sew_enc, input logic vm_b,
                                            input logic [63:0] a1, input logic [63:0] a2,
                                            input logic [63:0] m);
    logic [63:0] r;
    int sew;
    sew = 8 << sew_enc;
    for (int k = 0; k < 64; k++) begin
      int e;
      e = k / sew;
      r[k] = (vm_b || m[e]) ? a1[k] : a2[k];
    end
    return r;
  endfunction

  // Issue one operation; its result is due on the following cycle.
  task automatic drive(input string name, input logic [1:0] s, input logic m_b,
                       input logic [63:0] a2, input logic [63:0] a1, input logic [63:0] m,
                       input logic [63:0] expected);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    vsew     = s;
    vm       = m_b;
    vs2      = a2;
    vs1      = a1;
    v0       = m;
    e.vd     = expected;
    e.due    = cyc + 1;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      vs1      = {$urandom, $urandom};
      vs2      = {$urandom, $urandom};
      v0       = {$urandom, $urandom};
    end
  endtask

  // Monitor: pop on out_valid, flag missing/late results, check hold when idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out_valid: vd=%h with no operation outstanding (cycle %0d)",
                   vd, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_vec++;
          if (vd !== e.vd || cyc != e.due) begin
            n_err++;
            $display("FAIL %s: got vd=%h at cycle %0d, want vd=%h at cycle %0d",
                     e.name, vd, cyc, e.vd, e.due);
          end
          held = e.vd;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          n_vec++;
          n_err++;
          $display("FAIL %s_missing: out_valid=0 at cycle %0d, want vd=%h", e.name, cyc, e.vd);
        end
        n_vec++;
        if (vd !== held) begin
          n_err++;
          $display("FAIL hold: got vd=%h while idle, want %h", vd, held);
        end
      end
    end
  end

  initial begin
    logic [1:0]  s;
    logic        m_b;
    logic [63:0] a1, a2, m;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    vsew     = 2'b00;
    vm       = 1'b0;
    vs2      = 64'h0123_4567_89AB_CDEF;
    vs1      = 64'hFEDC_BA98_7654_3210;
    v0       = 64'h55;

    // Reset held with an operation present: it must be dropped.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || vd !== 64'h0) begin
        n_err++;
        $display("FAIL reset_%0d: got out_valid=%b vd=%h, want out_valid=0 vd=0",
                 i, out_valid, vd);
      end
    end
    mon_en = 1'b1;

    // SEW=64
    drive("sew64_v0_fe", 2'b11, 1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'hFFFF_FFFF_FFFF_FFFE, 64'h1111_1111_1111_1111);
    drive("sew64_v0_01", 2'b11, 1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h0000_0000_0000_0001, 64'h2222_2222_2222_2222);
    // SEW=32
    drive("sew32", 2'b10, 1'b0, 64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD,
          64'h2, 64'hCCCCCCCC_BBBBBBBB);
    // SEW=16
    drive("sew16", 2'b01, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h5, 64'h0000_FFFF_0000_FFFF);
    // SEW=8 merge then move with the same operands
    drive("sew8_merge", 2'b00, 1'b0, 64'h0706050403020100, 64'h8786858483828180,
          64'hA5, 64'h8706850403820180);
    drive("sew8_move", 2'b00, 1'b1, 64'h0706050403020100, 64'h8786858483828180,
          64'hA5, 64'h8786858483828180);
    // Unused high v0 bits must not leak in at SEW=16
    drive("sew16_v0_hi", 2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
          64'hFFFF_FFFF_FFFF_FFF0, 64'h1234_5678_9ABC_DEF0);
    idle(2);

    // Random back-to-back stream
    for (int i = 0; i < 200; i++) begin
      s   = 2'($urandom_range(0, 3));
      m_b = ($urandom_range(0, 3) == 0);
      a1  = {$urandom, $urandom};
      a2  = {$urandom, $urandom};
      m   = {$urandom, $urandom};
      drive("random", s, m_b, a2, a1, m, ref_merge(s, m_b, a1, a2, m));
      if ($urandom_range(0, 15) == 0) idle(1);
    end
    idle(4);

    // Bounded drain of anything still outstanding
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results never appeared, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_merge_unit.md
Name: vector_merge_unit

Overview:
- Element-wise masked merge datapath for one 64-bit vector register slice in the dragonfang vector execution stage.
- Each element takes its value from vs1 or vs2, selected by the mask bit in v0 that matches the element index (vmerge.v*m). An unmasked variant copies vs1 (vmv.v.*).
- Operand muxing for .vx/.vi forms is done upstream, so vs1 already carries the splatted scalar or immediate.
- One registered pipeline stage, 1-cycle latency, no backpressure.

Parameters:
- DATA_WIDTH, 64, datapath width in bits. Only 64 is supported.
- MASK_WIDTH, 8, number of v0 bits consumed. Equals DATA_WIDTH/8, the maximum element count at SEW=8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  operation present on the inputs this cycle
- vsew  input  2  element width: 00=8b, 01=16b, 10=32b, 11=64b (RVV vsew encoding)
- vm  input  1  0 = masked merge (vmerge); 1 = unmasked move (vmv), all elements from vs1
- vs2  input  64  source operand selected when the mask bit is 0
- vs1  input  64  source operand selected when the mask bit is 1, or for every element when vm=1
- v0  input  64  mask register; only bits [MASK_WIDTH-1:0] are used
- out_valid  output  1  vd holds a new result this cycle
- vd  output  64  merged result

Behaviour:
- Reset: when rst_n=0 at a rising edge, vd <= 0 and out_valid <= 0. Reset takes priority over in_valid. An operation present in the same cycle as reset is dropped.
- Latency: inputs sampled at edge N appear on vd at edge N+1, with out_valid=1 for exactly that one cycle per accepted operation. Back-to-back operations are accepted every cycle. There is no stall or ready signal.
- When in_valid=0, out_valid <= 0 and vd holds its previous value.
- Element partitioning: element i occupies bits [(i+1)*SEW-1 : i*SEW].
  - SEW=64: 1 element, uses v0[0].
  - SEW=32: 2 elements, use v0[1:0].
  - SEW=16: 4 elements, use v0[3:0].
  - SEW=8: 8 elements, use v0[7:0].
- Merge rule, vm=0: element i of vd = v0[i] ? element i of vs1 : element i of vs2.
- Move rule, vm=1: vd = vs1. v0 and vs2 are ignored.
- v0 bits above the active element count are ignored. For example, at SEW=64, v0[63:1] has no effect.
- Pure selection: no arithmetic, sign handling, carry, or cross-element interaction.
- vsew changes between consecutive operations take effect on the next operation with no bubble.
- The combinational merge network (per-byte select derived from vsew and v0) feeds the vd register directly. No X propagation from unused v0 bits.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, vd=0; first operation after release appears one cycle later.
- SEW=64, vm=0: vs2=0x1111_1111_1111_1111, vs1=0x2222_2222_2222_2222. With v0=0x...FE, vd=vs2. With v0=0x01, vd=vs1.
- SEW=32, vm=0: vs2=0xAAAAAAAA_BBBBBBBB, vs1=0xCCCCCCCC_DDDDDDDD, v0=0x2 -> vd=0xCCCCCCCC_BBBBBBBB.
- SEW=16, vm=0: vs2=0x0000_0000_0000_0000, vs1=0xFFFF_FFFF_FFFF_FFFF, v0=0x5 -> vd=0x0000_FFFF_0000_FFFF.
- SEW=8: vs2=0x0706050403020100, vs1=0x8786858483828180.
  - v0=0xA5, vm=0 -> vd=0x8706850403820180.
  - Next cycle, same operands with vm=1 -> vd=vs1.
- Streaming: random vs1/vs2/v0/vsew on consecutive cycles with in_valid=1, then in_valid=0.
  - Each result matches the reference model one cycle later.
  - After in_valid drops, out_valid falls and vd holds the last result.
